// File: rtl/usreg_pkg.sv
// Shared types and register-select encodings for the universal shift-register link controller.
package usreg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_SHIFT = 2'd1,
        RX_SHIFT = 2'd2,
        RX_HOLD  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_t;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    // MSB-first traffic moves toward the MSB end, LSB-first toward the LSB end.
    function automatic logic [1:0] shift_sel(input logic msb1st);
        return msb1st ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/usreg_core.sv
// Parameterized universal shift register: hold, shift right, shift left, parallel load.
module usreg_core
    import usreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next register contents selected by the operation code
    always_comb begin
        q_d = q_q;
        case (sel)
            SEL_HOLD: q_d = q_q;
            SEL_SHR:  q_d = {serial_in, q_q[WIDTH-1:1]};
            SEL_SHL:  q_d = {q_q[WIDTH-2:0], serial_in};
            SEL_LOAD: q_d = data_in;
            default:  q_d = q_q;
        endcase
    end

    // Register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/usreg_link_ctrl.sv
// TX/RX sequencer and round-robin arbiter sharing one universal shift register
// between a bus-side word interface and a serial pin pair.
module usreg_link_ctrl
    import usreg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_en,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_msb1st,
    output logic             ser_out,
    output logic             tx_done,
    input  logic             rx_req,
    input  logic             rx_msb1st,
    input  logic             ser_in,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             msb_q, msb_d;
    grant_t           last_grant_q, last_grant_d;
    logic             tx_done_q, tx_done_d;
    logic             rx_valid_q;
    logic             busy_q;
    logic             tx_grant_s;
    logic             tx_ready_s;
    logic [1:0]       sel_s;
    logic             core_ser_in_s;
    logic             ser_out_s;
    logic [WIDTH-1:0] reg_q_s;

    usreg_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel_s),
        .data_in   (tx_data),
        .serial_in (core_ser_in_s),
        .q         (reg_q_s)
    );

    assign cnt_inc_s = bit_cnt_q + CNT_ONE;

    // Next state, register operation and arbitration
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        msb_d        = msb_q;
        last_grant_d = last_grant_q;
        tx_done_d    = 1'b0;
        tx_ready_s   = 1'b0;
        sel_s        = SEL_HOLD;
        // On a tie, the side that was not served last wins
        tx_grant_s   = tx_valid && (!rx_req || (last_grant_q == GRANT_RX));
        case (state_q)
            IDLE: begin
                if (tx_grant_s) begin
                    tx_ready_s   = 1'b1;
                    sel_s        = SEL_LOAD;
                    msb_d        = tx_msb1st;
                    bit_cnt_d    = '0;
                    last_grant_d = GRANT_TX;
                    state_d      = TX_SHIFT;
                end else if (rx_req) begin
                    msb_d        = rx_msb1st;
                    bit_cnt_d    = '0;
                    last_grant_d = GRANT_RX;
                    state_d      = RX_SHIFT;
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            TX_SHIFT: begin
                if (ser_en) begin
                    sel_s     = shift_sel(msb_q);
                    bit_cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_LAST) begin
                        state_d   = IDLE;
                        tx_done_d = 1'b1;
                    end else begin
                        state_d = TX_SHIFT;
                    end
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            RX_SHIFT: begin
                if (ser_en) begin
                    sel_s     = shift_sel(msb_q);
                    bit_cnt_d = cnt_inc_s;
                    if (cnt_inc_s == CNT_LAST) begin
                        state_d = RX_HOLD;
                    end else begin
                        state_d = RX_SHIFT;
                    end
                end else begin
                    sel_s = SEL_HOLD;
                end
            end
            RX_HOLD: begin
                if (rx_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RX_HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outgoing words shift in zeros; only a receive takes the pin value
    always_comb begin
        if (state_q == RX_SHIFT) begin
            core_ser_in_s = ser_in;
        end else begin
            core_ser_in_s = 1'b0;
        end
    end

    // Serial output taps the end of the register that leaves first
    always_comb begin
        if (state_q == TX_SHIFT) begin
            ser_out_s = msb_q ? reg_q_s[WIDTH-1] : reg_q_s[0];
        end else begin
            ser_out_s = 1'b0;
        end
    end

    // Controller state and registered status decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            msb_q        <= 1'b0;
            last_grant_q <= GRANT_RX;
            tx_done_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            msb_q        <= msb_d;
            last_grant_q <= last_grant_d;
            tx_done_q    <= tx_done_d;
            rx_valid_q   <= (state_d == RX_HOLD);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign tx_ready = tx_ready_s;
    assign ser_out  = ser_out_s;
    assign tx_done  = tx_done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = reg_q_s;
    assign busy     = busy_q;

endmodule
